trans_mem_drain: RTL
====================

TRANS_MEM_DRAIN -- requirements
Module: trans_mem_drain

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the transaction-memory address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the transaction-memory data width.
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a drain; sampled only in IDLE.
REQ-006 abort  input  1  SHALL cancel a drain synchronously.
REQ-007 count  input  ADDR_W+1  SHALL give the number of entries to drain, sampled with start.
REQ-008 Trans_Mem1_ADDRB  output  ADDR_W  SHALL be the memory 1 port-B read address.
REQ-009 Trans_Mem1_RENB  output  1  SHALL be the memory 1 port-B read enable, active-high.
REQ-010 Trans_Mem1_DOUTB  input  DATA_W  SHALL be memory 1 read data, valid one cycle after RENB.
REQ-011 Trans_Mem2_ADDRB, Trans_Mem2_RENB and Trans_Mem2_DOUTB SHALL be identical in direction, width and meaning, for memory 2.
REQ-012 out_data  output  2*DATA_W  SHALL be the drained pair {mem1 byte, mem2 byte}.
REQ-013 out_index  output  ADDR_W  SHALL be the address the out_data pair came from.
REQ-014 out_valid / out_ready  output / input  1 each  SHALL form the output handshake.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.
REQ-016 done  output  1  SHALL pulse high for one cycle when a drain completes.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, READ and FLUSH.
  - IDLE -> READ: start=1 and count!=0.
  - READ -> FLUSH: the last read has been issued.
  - FLUSH -> IDLE: the last pair has been accepted, i.e. out_valid and out_ready in the same cycle.
REQ-018 If start=1 with count=0, the block SHALL pulse done in the next cycle, issue no reads, and remain in IDLE.
REQ-019 If count > 2^ADDR_W, it SHALL be clamped to 2^ADDR_W.
REQ-020 Reads SHALL be issued to both memories together, with the same ADDRB and both RENB high for one cycle; addresses SHALL run 0, 1, ... count-1.
REQ-021 Read data SHALL be captured the cycle after RENB into a 2-entry FIFO holding {data, index}; out_* SHALL be driven from the FIFO head.
REQ-022 A read SHALL be issued only when (fifo_count + reads_in_flight - pop_this_cycle) < 2, so the FIFO never overflows.
REQ-023 Latency: with start sampled at cycle t and out_ready=1, RENB SHALL be high in t+1 (address 0) and out_valid SHALL be high in t+3.
REQ-024 Throughput: with out_ready held high, the block SHALL produce one pair per cycle, and count pairs SHALL be delivered in cycles t+3 .. t+2+count.
REQ-025 Back-pressure: while out_valid=1 and out_ready=0, out_data and out_index SHALL hold stable and no read SHALL be issued beyond the FIFO space.
REQ-026 Address wrap: the address counter SHALL never exceed count-1; it SHALL not wrap within a drain.
REQ-027 done SHALL assert in the cycle after the final handshake and SHALL never coincide with out_valid of the same drain.
REQ-028 When abort=1 in READ or FLUSH, the block SHALL do the following in the next cycle:
  - clear the FIFO;
  - discard any read still in flight;
  - deassert out_valid;
  - return to IDLE without pulsing done.
REQ-029 When abort=1 in IDLE, it SHALL have no effect; abort SHALL take priority over start.
REQ-030 start asserted while busy SHALL be ignored.
REQ-031 When RENB is low, ADDRB SHALL hold its last value.

Reset
REQ-032 When reset=0, the block SHALL immediately force the following, independent of clock:
  - state IDLE;
  - FIFO empty, in-flight count 0;
  - RENB=0 and ADDRB=0 on both memories;
  - out_valid=0, out_data=0, out_index=0;
  - busy=0, done=0.
REQ-033 Reset deassertion SHALL be synchronised to clock before state may leave IDLE.

Structure
REQ-034 A shared package SHALL hold ADDR_W, DATA_W, the state enum typedef and the pair struct typedef {mem1, mem2, index}.
REQ-035 The 2-entry FIFO SHALL be one sub-module, pair_fifo, with push/pop/full/empty, reused for the output stage.

Verification
REQ-036 Reset, mem1[i]=8'h10+i and mem2[i]=8'hA0+i, start with count=4, out_ready=1 -> pairs 16'h10A0, 16'h11A1, 16'h12A2, 16'h13A3 with indices 0..3 at t+3..t+6, then done at t+7.
REQ-037 count=16, out_ready toggling 1/0 every cycle -> all 16 pairs delivered in order, data stable while stalled, no FIFO overflow, done once.
REQ-038 count=0 -> done pulse at t+1, RENB never high, busy stays 0.
REQ-039 count=5 with abort at t+3 -> out_valid low at t+4, no done, busy 0; a new start with count=2 then yields indices 0,1 only.
REQ-040 reset driven low mid-FLUSH with out_valid=1 -> all outputs at reset values asynchronously; after release, start with count=1 works normally.
REQ-041 start pulsed again while busy, with count=8 then count=3 -> exactly 8 pairs and one done.

Source files
------------

// File: rtl/trans_mem_drain_pkg.sv
// Shared types and default widths for the transaction-memory drain block.
// Imported by the interface, the pair FIFO and the drain top.
package trans_mem_drain_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      FLUSH
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] mem1;
      logic [DATA_W-1:0] mem2;
      logic [ADDR_W-1:0] index;
   } pair_t;

endpackage

// File: rtl/trans_mem_drain_if.sv
// Memory port-B read buses and the drained-pair output handshake.
// master is the drain block, slave is the memories plus the consumer.
interface trans_mem_drain_if #(
   parameter int ADDR_W = trans_mem_drain_pkg::ADDR_W,
   parameter int DATA_W = trans_mem_drain_pkg::DATA_W
);

   logic [ADDR_W-1:0]   Trans_Mem1_ADDRB;
   logic                Trans_Mem1_RENB;
   logic [DATA_W-1:0]   Trans_Mem1_DOUTB;
   logic [ADDR_W-1:0]   Trans_Mem2_ADDRB;
   logic                Trans_Mem2_RENB;
   logic [DATA_W-1:0]   Trans_Mem2_DOUTB;
   logic [2*DATA_W-1:0] out_data;
   logic [ADDR_W-1:0]   out_index;
   logic                out_valid;
   logic                out_ready;

   modport master (
      output Trans_Mem1_ADDRB, Trans_Mem1_RENB,
      input  Trans_Mem1_DOUTB,
      output Trans_Mem2_ADDRB, Trans_Mem2_RENB,
      input  Trans_Mem2_DOUTB,
      output out_data, out_index, out_valid,
      input  out_ready
   );

   modport slave (
      input  Trans_Mem1_ADDRB, Trans_Mem1_RENB,
      output Trans_Mem1_DOUTB,
      input  Trans_Mem2_ADDRB, Trans_Mem2_RENB,
      output Trans_Mem2_DOUTB,
      input  out_data, out_index, out_valid,
      output out_ready
   );

endinterface

// File: rtl/trans_mem_drain_fifo.sv
// Two-entry FIFO of {mem1, mem2, index} pairs; its head drives the output.
// clear empties it in one cycle and wins over push/pop.
module pair_fifo
   import trans_mem_drain_pkg::*;
(
   input  logic  clock,
   input  logic  reset,
   input  logic  clear,
   input  logic  push,
   input  pair_t din,
   input  logic  pop,
   output pair_t head,
   output logic  full,
   output logic  empty
);

   pair_t      mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] cnt;
   logic       do_push;
   logic       do_pop;

   assign full    = (cnt == 2'd2);
   assign empty   = (cnt == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else if (clear) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/trans_mem_drain.sv
// Drains count entries from two transaction memories in lock-step and
// streams {mem1, mem2} pairs with their address over valid/ready.
module trans_mem_drain #(
   parameter int ADDR_W = trans_mem_drain_pkg::ADDR_W,
   parameter int DATA_W = trans_mem_drain_pkg::DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   count,
   trans_mem_drain_if.master bus,
   output logic              busy,
   output logic              done
);
   import trans_mem_drain_pkg::*;

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   state_t            state;
   state_t            state_nx;
   logic [1:0]        arm_q;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   len_in;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W-1:0] last_addr;
   logic              cap_q;
   logic              done_q;
   logic              accept;
   logic              ren;
   logic              pop;
   logic              last_pop;
   logic              flush;
   logic              fifo_full;
   logic              fifo_empty;
   logic [1:0]        lvl;
   logic [2:0]        occ;
   logic              space_ok;
   pair_t             din;
   pair_t             head;

   assign len_in = (count > MAX_LEN) ? MAX_LEN : count;
   assign accept = (state == IDLE) && arm_q[1] && start && !abort;
   assign flush  = abort && (state != IDLE);
   assign pop    = bus.out_valid && bus.out_ready;

   assign last_pop = pop &&
      ({1'b0, head.index} == len_q - 1'b1);

   // Every read not yet handed off must still fit in the FIFO.
   assign lvl      = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
   assign occ      = {1'b0, lvl} + {2'b0, cap_q};
   assign space_ok = (occ - {2'b0, pop}) < 3'd2;

   assign ren = (state == READ) && !abort &&
                (rd_ptr < len_q) && space_ok;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (accept && (count != '0))
               state_nx = READ;
         READ:
            if (abort)
               state_nx = IDLE;
            else if (ren && (rd_ptr == len_q - 1'b1))
               state_nx = FLUSH;
         FLUSH:
            if (abort || last_pop)
               state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         arm_q     <= 2'b00;
         len_q     <= '0;
         rd_ptr    <= '0;
         last_addr <= '0;
         cap_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state <= state_nx;
         arm_q <= {arm_q[0], 1'b1};
         cap_q <= ren;
         if (accept) begin
            len_q  <= len_in;
            rd_ptr <= '0;
         end else if (ren) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (ren)
            last_addr <= rd_ptr[ADDR_W-1:0];
         done_q <= (accept && (count == '0)) ||
                   ((state == FLUSH) && !abort && last_pop);
      end
   end

   // last_addr still names the read whose data is on DOUTB now.
   assign din = '{mem1:  bus.Trans_Mem1_DOUTB,
                  mem2:  bus.Trans_Mem2_DOUTB,
                  index: last_addr};

   pair_fifo u_fifo (
      .clock (clock),
      .reset (reset),
      .clear (flush),
      .push  (cap_q),
      .din   (din),
      .pop   (pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.Trans_Mem1_RENB  = ren;
   assign bus.Trans_Mem2_RENB  = ren;
   assign bus.Trans_Mem1_ADDRB = ren ? rd_ptr[ADDR_W-1:0] : last_addr;
   assign bus.Trans_Mem2_ADDRB = ren ? rd_ptr[ADDR_W-1:0] : last_addr;
   assign bus.out_valid        = !fifo_empty;
   assign bus.out_data         = {head.mem1, head.mem2};
   assign bus.out_index        = head.index;

   assign busy = (state != IDLE);
   assign done = done_q;

endmodule
